lsu_bus_ctrl: RTL and testbench

//  Load/store unit between the multicycle datapath's MEM stage and the data-memory bus.

---
 rtl/lsu_pkg.sv | 48 ++++
 rtl/lsu_data_align.sv | 47 ++++
 rtl/lsu_bus_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_lsu_bus_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit bus controller.
// Holds the FSM state encoding, funct3 width codes and access legality checks.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int CNT_W = 10;

    function automatic logic is_misaligned(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic r;
        r = 1'b0;
        case (f3)
            F3_H, F3_HU: r = off[0];
            F3_W:        r = (off != 2'b00);
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

    // Stores only have signed-less B/H/W encodings; loads add BU/HU.
    function automatic logic is_illegal(
        input logic       we,
        input logic [2:0] f3
    );
        logic r;
        r = 1'b1;
        case (f3)
            F3_B, F3_H, F3_W: r = 1'b0;
            F3_BU, F3_HU:     r = we;
            default:          r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane steering for stores and extract/extend for loads.
// Purely combinational so the cache path can reuse it unchanged.
module lsu_data_align
    import lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = rdata_in >> {off, 3'b000};
        be        = 4'b1111;
        wdata_out = wdata_in;
        rdata_out = shifted;
        case (func3)
            F3_B: begin
                be        = 4'b0001 << off;
                wdata_out = {4{wdata_in[7:0]}};
                rdata_out = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_H: begin
                be        = 4'b0011 << off;
                wdata_out = {2{wdata_in[15:0]}};
                rdata_out = {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_BU: begin
                rdata_out = {24'h0, shifted[7:0]};
            end
            F3_HU: begin
                rdata_out = {16'h0, shifted[15:0]};
            end
            default: begin
                be        = 4'b1111;
                wdata_out = wdata_in;
                rdata_out = shifted;
            end
        endcase
    end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// MEM-stage load/store controller driving a valid/ready data-memory bus.
// All outputs are registered; illegal or misaligned requests never reach the bus.
module lsu_bus_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [31:0] busAddr,
    input  logic [31:0] busWData,
    output logic [31:0] busRData,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               we_q, we_d;
    logic [2:0]         f3_q, f3_d;
    logic [1:0]         off_q, off_d;
    logic               ill_q, ill_d;

    logic [31:0]        rdata_q, rdata_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               mvalid_q, mvalid_d;
    logic               mwe_q, mwe_d;
    logic [31:0]        maddr_q, maddr_d;
    logic [3:0]         mbe_q, mbe_d;
    logic [31:0]        mwdata_q, mwdata_d;

    logic [2:0]         sel_f3;
    logic [1:0]         sel_off;
    logic [3:0]         al_be;
    logic [31:0]        al_wdata;
    logic [31:0]        al_rdata;
    logic               bad_req;

    // IDLE steers the incoming store; afterwards the latched code extracts the load.
    assign sel_f3  = (state_q == IDLE) ? func3 : f3_q;
    assign sel_off = (state_q == IDLE) ? busAddr[1:0] : off_q;
    assign bad_req = is_illegal(we, func3) | is_misaligned(func3, busAddr[1:0]);
    assign cnt_nxt = cnt_q + 1'b1;

    lsu_data_align u_align (
        .func3     (sel_f3),
        .off       (sel_off),
        .wdata_in  (busWData),
        .rdata_in  (mem_rdata),
        .be        (al_be),
        .wdata_out (al_wdata),
        .rdata_out (al_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        f3_d     = f3_q;
        off_d    = off_q;
        ill_d    = ill_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        mvalid_d = mvalid_q;
        mwe_d    = mwe_q;
        maddr_d  = maddr_q;
        mbe_d    = mbe_q;
        mwdata_d = mwdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d  = we;
                    f3_d  = func3;
                    off_d = busAddr[1:0];
                    if (bad_req) begin
                        state_d = RESP;
                        ill_d   = 1'b1;
                    end else begin
                        state_d  = ACCESS;
                        cnt_d    = '0;
                        mvalid_d = 1'b1;
                        mwe_d    = we;
                        maddr_d  = {busAddr[31:2], 2'b00};
                        mbe_d    = we ? al_be : 4'b1111;
                        mwdata_d = we ? al_wdata : 32'h0;
                    end
                end
            end
            ACCESS: begin
                // A ready on the timeout cycle still completes normally.
                if (mem_ready) begin
                    state_d  = RESP;
                    mvalid_d = 1'b0;
                    mwe_d    = 1'b0;
                    done_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = al_rdata;
                    end
                end else if (cnt_nxt == CNT_W'(TIMEOUT)) begin
                    state_d  = RESP;
                    cnt_d    = cnt_nxt;
                    mvalid_d = 1'b0;
                    mwe_d    = 1'b0;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_nxt;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (ill_q) begin
                    ill_d  = 1'b0;
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            f3_q     <= 3'b000;
            off_q    <= 2'b00;
            ill_q    <= 1'b0;
            rdata_q  <= 32'h0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            mvalid_q <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= 32'h0;
            mbe_q    <= 4'b0000;
            mwdata_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            f3_q     <= f3_d;
            off_q    <= off_d;
            ill_q    <= ill_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            mvalid_q <= mvalid_d;
            mwe_q    <= mwe_d;
            maddr_q  <= maddr_d;
            mbe_q    <= mbe_d;
            mwdata_q <= mwdata_d;
        end
    end

    assign busRData  = rdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign mem_valid = mvalid_q;
    assign mem_we    = mwe_q;
    assign mem_addr  = maddr_q;
    assign mem_be    = mbe_q;
    assign mem_wdata = mwdata_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl with a short timeout to exercise the error path.
module tb_lsu_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [2:0]  func3;
    logic [31:0] busAddr;
    logic [31:0] busWData;
    logic [31:0] busRData;
    logic        done;
    logic        err;
    logic        busy;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int nvec = 0;
    int nerr = 0;

    lsu_bus_ctrl #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .func3     (func3),
        .busAddr   (busAddr),
        .busWData  (busWData),
        .busRData  (busRData),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Holds req for exactly one cycle T; returns at T+1.
    task automatic issue(input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d);
        req      = 1'b1;
        we       = w;
        func3    = f;
        busAddr  = a;
        busWData = d;
        step();
        req = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req       = 1'b0;
        we        = 1'b0;
        func3     = 3'b000;
        busAddr   = 32'h0;
        busWData  = 32'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_valid", mem_valid, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_rdata", busRData, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        step();

        // SW a=0x100
        issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        chk("sw_valid", mem_valid, 1);
        chk("sw_we", mem_we, 1);
        chk("sw_addr", mem_addr, 32'h100);
        chk("sw_be", mem_be, 4'b1111);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_busy", busy, 1);
        chk("sw_nodone", done, 0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("sw_done", done, 1);
        chk("sw_err", err, 0);
        chk("sw_valid_off", mem_valid, 0);
        step();
        chk("sw_pulse", done, 0);
        chk("sw_idle", busy, 0);

        // SB a=0x103
        issue(1'b1, 3'b000, 32'h103, 32'h000000A5);
        chk("sb_be", mem_be, 4'b1000);
        chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("sb_addr", mem_addr, 32'h100);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("sb_done", done, 1);
        chk("sb_keep", busRData, 32'h0);
        step();

        // SH a=0x102
        issue(1'b1, 3'b001, 32'h102, 32'h1234BEEF);
        chk("sh_be", mem_be, 4'b1100);
        chk("sh_wdata", mem_wdata, 32'hBEEFBEEF);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();

        // LB a=0x103
        issue(1'b0, 3'b000, 32'h103, 32'h0);
        chk("lb_we", mem_we, 0);
        chk("lb_be", mem_be, 4'b1111);
        mem_ready = 1'b1;
        mem_rdata = 32'hA5000000;
        step();
        mem_ready = 1'b0;
        chk("lb_done", done, 1);
        chk("lb_err", err, 0);
        chk("lb_data", busRData, 32'hFFFFFFA5);
        step();

        // LHU then LH at 0x102
        issue(1'b0, 3'b101, 32'h102, 32'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'h80010000;
        step();
        mem_ready = 1'b0;
        chk("lhu_data", busRData, 32'h00008001);
        step();
        issue(1'b0, 3'b001, 32'h102, 32'h0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("lh_data", busRData, 32'hFFFF8001);
        step();

        // Misaligned LW a=0x101
        issue(1'b0, 3'b010, 32'h101, 32'h0);
        chk("mis_novalid", mem_valid, 0);
        chk("mis_busy", busy, 1);
        chk("mis_nodone", done, 0);
        step();
        chk("mis_done", done, 1);
        chk("mis_err", err, 1);
        chk("mis_keep", busRData, 32'hFFFF8001);
        step();
        chk("mis_pulse", done, 0);

        // Illegal store func3 011
        issue(1'b1, 3'b011, 32'h200, 32'h11111111);
        chk("ill_novalid", mem_valid, 0);
        step();
        chk("ill_done", done, 1);
        chk("ill_err", err, 1);
        step();

        // LW timeout with a stray req during the wait
        issue(1'b0, 3'b010, 32'h200, 32'h0);
        chk("to_v1", mem_valid, 1);
        issue(1'b1, 3'b010, 32'h300, 32'h55555555);
        chk("to_v2", mem_valid, 1);
        chk("to_addr_hold", mem_addr, 32'h200);
        chk("to_we_hold", mem_we, 0);
        step();
        chk("to_v3", mem_valid, 1);
        step();
        chk("to_v4", mem_valid, 1);
        chk("to_nodone", done, 0);
        step();
        chk("to_drop", mem_valid, 0);
        chk("to_done", done, 1);
        chk("to_err", err, 1);
        chk("to_keep", busRData, 32'hFFFF8001);
        step();
        chk("to_pulse", done, 0);
        step();
        chk("to_idle", busy, 0);

        // Ready on the timeout cycle wins
        issue(1'b0, 3'b010, 32'h204, 32'h0);
        step();
        step();
        step();
        mem_ready = 1'b1;
        mem_rdata = 32'h12345678;
        step();
        mem_ready = 1'b0;
        chk("race_done", done, 1);
        chk("race_err", err, 0);
        chk("race_data", busRData, 32'h12345678);
        step();

        // Reset on second ACCESS cycle
        issue(1'b0, 3'b010, 32'h400, 32'h0);
        chk("ra_v1", mem_valid, 1);
        step();
        chk("ra_v2", mem_valid, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("ra_valid", mem_valid, 0);
        chk("ra_busy", busy, 0);
        chk("ra_done", done, 0);
        chk("ra_rdata", busRData, 0);
        chk("ra_addr", mem_addr, 0);
        step();
        chk("ra_nodone", done, 0);
        chk("ra_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
